// File: rtl/awgn_run_ctrl_pkg.sv
// Shared types and constants for the AWGN run controller.
package awgn_ctrl_pkg;

  localparam int unsigned SAMPLE_W  = 17;
  localparam int unsigned NUM_SEEDS = 6;

  // Tausworthe components degenerate below these values.
  localparam logic [31:0] SEED_MIN0 = 32'd2;
  localparam logic [31:0] SEED_MIN1 = 32'd8;
  localparam logic [31:0] SEED_MIN2 = 32'd16;

  // Power-on seeds: all above the minimums, all distinct, A differs from B.
  localparam logic [31:0] SEED_DEF0 = 32'h1234_5678;
  localparam logic [31:0] SEED_DEF1 = 32'h9ABC_DEF0;
  localparam logic [31:0] SEED_DEF2 = 32'h0F1E_2D3C;
  localparam logic [31:0] SEED_DEF3 = 32'h4B5A_6978;
  localparam logic [31:0] SEED_DEF4 = 32'h8796_A5B4;
  localparam logic [31:0] SEED_DEF5 = 32'hC3D2_E1F0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DONE
  } ctrl_state_t;

  function automatic logic [31:0] seed_default(input int unsigned idx);
    case (idx)
      0:       return SEED_DEF0;
      1:       return SEED_DEF1;
      2:       return SEED_DEF2;
      3:       return SEED_DEF3;
      4:       return SEED_DEF4;
      default: return SEED_DEF5;
    endcase
  endfunction

  // One generator's three seeds against the component minimums.
  function automatic logic triple_ok(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c);
    return (a >= SEED_MIN0) && (b >= SEED_MIN1) && (c >= SEED_MIN2);
  endfunction

endpackage

// File: rtl/awgn_run_ctrl_if.sv
// Host/config and noise-core signals of the run controller.
interface awgn_run_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // host side
  logic                                 seed_we;
  logic [2:0]                           seed_addr;
  logic [31:0]                          seed_data;
  logic                                 start;
  logic                                 abort;
  logic [CNT_W-1:0]                     num_samples;
  logic [awgn_ctrl_pkg::SAMPLE_W-1:0]   x0;
  logic [awgn_ctrl_pkg::SAMPLE_W-1:0]   x1;
  logic                                 sample_valid;
  logic                                 busy;
  logic                                 done;
  logic                                 seed_err;
  // core side
  logic [awgn_ctrl_pkg::SAMPLE_W-1:0]   core_x0;
  logic [awgn_ctrl_pkg::SAMPLE_W-1:0]   core_x1;
  logic                                 core_reset;
  logic [31:0]                          s0, s1, s2, s3, s4, s5;

  modport master (
    output seed_we, seed_addr, seed_data, start, abort, num_samples, core_x0, core_x1,
    input  x0, x1, sample_valid, busy, done, seed_err, core_reset, s0, s1, s2, s3, s4, s5
  );

  modport slave (
    input  seed_we, seed_addr, seed_data, start, abort, num_samples, core_x0, core_x1,
    output x0, x1, sample_valid, busy, done, seed_err, core_reset, s0, s1, s2, s3, s4, s5
  );
endinterface

// File: rtl/awgn_seed_bank.sv
// Six 32-bit Tausworthe seed registers with write decode and validity check.
module awgn_seed_bank
  import awgn_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [31:0]       data,
  output logic [5:0][31:0]  seeds,
  output logic              seeds_ok
);

  // Load defaults on reset; addresses 6 and 7 match no register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SEEDS; i++) seeds[i] <= seed_default(i);
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_SEEDS; i++)
        if (addr == 3'(i)) seeds[i] <= data;
    end
  end

  // Both generators must clear the minimums, judged on stored contents only.
  always_comb begin
    seeds_ok = triple_ok(seeds[0], seeds[1], seeds[2]) &&
               triple_ok(seeds[3], seeds[4], seeds[5]);
  end

endmodule

// File: rtl/awgn_run_ctrl.sv
// Run controller: seeds the noise core, waits out its latency, streams a
// fixed number of (x0, x1) pairs and signals completion.
module awgn_run_ctrl
  import awgn_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           reset,
  awgn_run_ctrl_if.slave bus
);

  localparam int unsigned LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  ctrl_state_t      state;
  logic [CNT_W-1:0] remain;
  logic [LAT_W-1:0] lat;
  logic [5:0][31:0] seeds;
  logic             seeds_ok;
  logic             seed_wr;

  assign seed_wr = bus.seed_we && (state == ST_IDLE);

  awgn_seed_bank u_seed_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (seed_wr),
    .addr     (bus.seed_addr),
    .data     (bus.seed_data),
    .seeds    (seeds),
    .seeds_ok (seeds_ok)
  );

  assign bus.s0 = seeds[0];
  assign bus.s1 = seeds[1];
  assign bus.s2 = seeds[2];
  assign bus.s3 = seeds[3];
  assign bus.s4 = seeds[4];
  assign bus.s5 = seeds[5];

  // Run sequencing with registered outputs. RUN holds one extra cycle with
  // remain == 0 so that done lands the cycle after the last valid pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      bus.core_reset   <= 1'b1;
      bus.x0           <= '0;
      bus.x1           <= '0;
      bus.sample_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.seed_err     <= 1'b0;
      remain           <= '0;
      lat              <= '0;
    end else begin
      bus.done         <= 1'b0;
      bus.seed_err     <= 1'b0;
      bus.sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (!seeds_ok) begin
              bus.seed_err <= 1'b1;
            end else if (bus.num_samples == '0) begin
              state    <= ST_DONE;
              bus.busy <= 1'b1;
              bus.done <= 1'b1;
            end else begin
              state          <= ST_PRIME;
              bus.busy       <= 1'b1;
              bus.core_reset <= 1'b0;
              remain         <= bus.num_samples;
              lat            <= '0;
            end
          end
        end
        ST_PRIME: begin
          if (bus.abort) begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.core_reset <= 1'b1;
          end else if (lat == LAT_W'(PIPE_LAT - 1)) begin
            state <= ST_RUN;
          end else begin
            lat <= lat + LAT_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.core_reset <= 1'b1;
          end else if (remain != '0) begin
            bus.x0           <= bus.core_x0;
            bus.x1           <= bus.core_x1;
            bus.sample_valid <= 1'b1;
            remain           <= remain - CNT_W'(1);
          end else begin
            state          <= ST_DONE;
            bus.done       <= 1'b1;
            bus.core_reset <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          bus.busy       <= 1'b0;
          bus.core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_awgn_run_ctrl.sv
// Directed bench for awgn_run_ctrl: single-cycle control vectors plus
// multi-cycle run, abort, interference and reset sequences.
module tb_awgn_run_ctrl;
  import awgn_ctrl_pkg::*;

  localparam int unsigned PIPE_LAT = 6;
  localparam int unsigned CNT_W    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  awgn_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  awgn_run_ctrl #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_seed [6];
  logic [33:0] stream   [16];
  logic [33:0] saved    [16];

  // Stand-in noise core: output depends on seeds and cycles since release.
  int unsigned k = 0;
  always @(posedge clk) begin
    if (bus.core_reset) k <= 0;
    else                k <= k + 1;
  end
  assign bus.core_x0 = 17'((bus.s0 ^ bus.s3) + k * 7);
  assign bus.core_x1 = 17'((bus.s1 ^ bus.s4) + k * 13 + 1);

  function automatic logic [16:0] mx0(input int unsigned kk);
    return 17'((exp_seed[0] ^ exp_seed[3]) + kk * 7);
  endfunction

  function automatic logic [16:0] mx1(input int unsigned kk);
    return 17'((exp_seed[1] ^ exp_seed[4]) + kk * 13 + 1);
  endfunction

  function automatic logic [31:0] get_s(input int unsigned i);
    case (i)
      0:       return bus.s0;
      1:       return bus.s1;
      2:       return bus.s2;
      3:       return bus.s3;
      4:       return bus.s4;
      default: return bus.s5;
    endcase
  endfunction

  // {busy, done, seed_err, core_reset, sample_valid}
  function automatic logic [4:0] status();
    return {bus.busy, bus.done, bus.seed_err, bus.core_reset, bus.sample_valid};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.seed_we     = 1'b0;
    bus.seed_addr   = 3'd0;
    bus.seed_data   = 32'd0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.num_samples = '0;
  endtask

  task automatic check_seeds(input string tag);
    for (int unsigned i = 0; i < 6; i++)
      chk($sformatf("%s s%0d", tag, i), 64'(get_s(i)), 64'(exp_seed[i]));
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 6; i++) exp_seed[i] = seed_default(i);
    chk({tag, " status"}, 64'(status()), 64'(5'b00010));
    chk({tag, " x0"}, 64'(bus.x0), 64'd0);
    chk({tag, " x1"}, 64'(bus.x1), 64'd0);
    check_seeds(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One run from IDLE; c counts cycles after the accepting edge.
  task automatic run_seq(input string tag, input int n, input int abort_at, input bit meddle);
    int d;
    int last;
    logic [4:0] e;
    d    = PIPE_LAT + n + 2;
    last = (abort_at != 0) ? abort_at + 3 : d + 2;
    @(negedge clk);
    idle_in();
    bus.start       = 1'b1;
    bus.num_samples = CNT_W'(n);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && c > abort_at) begin
        e = 5'b00010;
      end else begin
        e[4] = (c <= d);
        e[3] = (c == d);
        e[2] = 1'b0;
        e[1] = (c >= d);
        e[0] = (c >= PIPE_LAT + 2) && (c <= PIPE_LAT + 1 + n);
      end
      chk($sformatf("%s status c=%0d", tag, c), 64'(status()), 64'(e));
      if (e[0]) begin
        chk($sformatf("%s x0 c=%0d", tag, c), 64'(bus.x0), 64'(mx0(c - 2)));
        chk($sformatf("%s x1 c=%0d", tag, c), 64'(bus.x1), 64'(mx1(c - 2)));
        stream[c - PIPE_LAT - 2] = {bus.x0, bus.x1};
      end
      @(negedge clk);
      idle_in();
      if (abort_at != 0 && c == abort_at) bus.abort = 1'b1;
      if (meddle && c == PIPE_LAT + 2) begin
        bus.seed_we     = 1'b1;
        bus.seed_addr   = 3'd0;
        bus.seed_data   = 32'd0;
        bus.start       = 1'b1;
        bus.num_samples = CNT_W'(1);
      end
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        start;
    logic        abort;
    logic [15:0] num;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl [25];

  initial begin
    // we addr data start abort num {busy,done,err,core_reset,valid}
    tbl[0]  = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[1]  = '{1'b1, 3'd1, 32'd5,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[2]  = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd4, 5'b00110};
    tbl[3]  = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[4]  = '{1'b1, 3'd1, 32'd100, 1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[5]  = '{1'b1, 3'd6, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[6]  = '{1'b1, 3'd7, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[7]  = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd0, 5'b11010};
    tbl[8]  = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[9]  = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b1, 16'd0, 5'b11010};
    tbl[10] = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b1, 16'd0, 5'b00010};
    tbl[11] = '{1'b1, 3'd0, 32'd1,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[12] = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd3, 5'b00110};
    tbl[13] = '{1'b1, 3'd0, 32'd2,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[14] = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd0, 5'b11010};
    tbl[15] = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[16] = '{1'b1, 3'd0, 32'd1,   1'b1, 1'b0, 16'd0, 5'b11010};
    tbl[17] = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[18] = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd0, 5'b00110};
    tbl[19] = '{1'b1, 3'd0, 32'd2,   1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[20] = '{1'b1, 3'd5, 32'd15,  1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[21] = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd0, 5'b00110};
    tbl[22] = '{1'b1, 3'd5, 32'd16,  1'b0, 1'b0, 16'd0, 5'b00010};
    tbl[23] = '{1'b0, 3'd0, 32'd0,   1'b1, 1'b0, 16'd0, 5'b11010};
    tbl[24] = '{1'b0, 3'd0, 32'd0,   1'b0, 1'b0, 16'd0, 5'b00010};

    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    reset_and_check("por");

    run_seq("run_default", 4, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.seed_we     = tbl[i].we;
      bus.seed_addr   = tbl[i].addr;
      bus.seed_data   = tbl[i].data;
      bus.start       = tbl[i].start;
      bus.abort       = tbl[i].abort;
      bus.num_samples = tbl[i].num;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d status", i), 64'(status()), 64'(tbl[i].exp));
    end
    @(negedge clk);
    idle_in();
    exp_seed[0] = 32'd2;
    exp_seed[1] = 32'd100;
    exp_seed[5] = 32'd16;
    check_seeds("after_vec");

    run_seq("run_meddle", 4, 0, 1'b1);
    check_seeds("after_meddle");
    for (int i = 0; i < 4; i++) saved[i] = stream[i];
    for (int i = 0; i < 4; i++) stream[i] = '0;
    run_seq("run_repeat", 4, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("repeat pair%0d", i), 64'(stream[i]), 64'(saved[i]));

    run_seq("run_abort", 10, PIPE_LAT + 2, 1'b0);

    // reset while streaming
    @(negedge clk);
    idle_in();
    bus.start       = 1'b1;
    bus.num_samples = CNT_W'(10);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    repeat (8) @(posedge clk);
    #1;
    chk("midrun valid", 64'(bus.sample_valid), 64'd1);
    reset_and_check("midrun_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/awgn_run_ctrl.md
# awgn_run_ctrl

Run controller for the AWGN noise generator core. It holds the six 32-bit Tausworthe seeds and keeps the core in reset while idle. On `start` it releases the core, waits out the pipeline latency, then presents exactly `num_samples` (x0, x1) pairs with a valid strobe and pulses `done`. It sits between the host/config logic and the noise core's `s0..s5`/`reset` inputs and `x0`/`x1` outputs.

## Interface
- `PIPE_LAT`, default 6: cycles from core reset release to first valid core output (the log/sqrt/sin-cos path depth).
- `CNT_W`, default 16: width of the sample counter.
- `clk` in 1: single clock; everything is clocked on the rising edge.
- `reset` in 1: synchronous, active-high.
- `seed_we` in 1: seed write strobe; honoured only in IDLE.
- `seed_addr` in 3: seed index 0..5; values 6 and 7 are ignored.
- `seed_data` in 32: seed value to write.
- `start` in 1: run request; honoured only in IDLE.
- `abort` in 1: terminate the run and return to IDLE.
- `num_samples` in CNT_W: pair count, latched at start.
- `core_x0` in 17: noise core output x0.
- `core_x1` in 17: noise core output x1.
- `core_reset` out 1: drives the noise core reset.
- `s0`..`s5` out 32 each: seed registers, driven to the core.
- `x0` out 17: registered sample output.
- `x1` out 17: registered sample output.
- `sample_valid` out 1: `x0`/`x1` hold a valid pair this cycle.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `seed_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States are IDLE, PRIME, RUN and DONE.
- Reset values:
  - state = IDLE, `core_reset` = 1.
  - `s0..s5` = package defaults.
  - `x0` = `x1` = 0.
  - `sample_valid`, `busy`, `done` and `seed_err` = 0.
  - Counters = 0.
- IDLE:
  - `core_reset` = 1, so the core continuously reloads the seeds.
  - `seed_we` writes `seed_data` into seed[`seed_addr`] on the next edge.
- Start in IDLE: the seeds are checked first.
  - Generator A (s0, s1, s2) requires s0 > 1, s1 > 7, s2 > 15. Generator B (s3, s4, s5) uses the same limits.
  - The check uses register contents, not a same-cycle `seed_we`.
  - If any limit fails: `seed_err` pulses, state stays IDLE.
  - If `num_samples` == 0: go directly to DONE.
  - Otherwise: latch `num_samples`, clear the latency counter, go to PRIME.
- PRIME:
  - `core_reset` = 0.
  - The latency counter counts PIPE_LAT cycles, then state goes to RUN.
- RUN:
  - Each cycle `core_x0`/`core_x1` are registered into `x0`/`x1`, `sample_valid` is 1, and the remaining count decrements.
  - When the count reaches 0, state goes to DONE.
- DONE:
  - `done` = 1 for one cycle, `core_reset` = 1.
  - Next state is IDLE.
- Abort in PRIME or RUN:
  - Next state is IDLE, `core_reset` = 1.
  - `sample_valid` = 0 from the next cycle; no `done` pulse.
  - Abort in IDLE or DONE has no effect.
- Priority: `reset` > `abort` > `start`.
- In non-IDLE states, `start` and `seed_we` are ignored and the seeds are unchanged.
- No backpressure: the consumer must accept one pair per cycle while `sample_valid` is high.

## Timing
- Start accepted at edge T (state IDLE): state = PRIME and `core_reset` = 0 from T+1.
- State = RUN from T+1+PIPE_LAT. The first `sample_valid` is at T+2+PIPE_LAT because of the output register.
- Exactly `num_samples` consecutive `sample_valid` cycles, with no gaps.
- `done` is asserted in the cycle after the last `sample_valid`.
- `busy` is high from T+1 through the `done` cycle inclusive.
- A seed write at edge W is visible on `s*` from W+1 and is usable by a start at W+1 or later.
- Maximum run length is 2^CNT_W − 1 pairs; the counter does not wrap.
- Back-to-back runs: a new start is accepted on the first IDLE cycle after `done`, and the core is reseeded from the same seeds, giving an identical sequence.

## Structure
- Package `awgn_ctrl_pkg` holds:
  - the state enum;
  - the seed minimum constants 2, 8 and 16;
  - the six default seed constants, valid and distinct, with generators A and B differing;
  - the sample width 17.
- Sub-module `awgn_seed_bank` contains the 6×32 seed registers, the write decode and the combinational `seeds_ok` check.
- The FSM, counters and output register live in the top.

## Test plan
- Reset, then start with `num_samples` = 4 and PIPE_LAT = 6 (start at T): `core_reset` falls at T+1, `sample_valid` is high for cycles T+8..T+11 with `x0`/`x1` equal to the one-cycle-delayed core inputs, and `done` is at T+12.
- Write s1 = 5 via `seed_addr` = 1, then start: `seed_err` pulses, `busy` stays 0 and `core_reset` stays 1; rewriting s1 = 100 and starting again runs normally.
- Start with `num_samples` = 0: `done` pulses on the next cycle, and `sample_valid` is never asserted.
- Abort on the 2nd RUN cycle of a 10-sample run: `sample_valid` falls on the next cycle, state is IDLE, `core_reset` = 1, and there is no `done`.
- `seed_we` and `start` issued during RUN: the seeds are unchanged and the run completes with the original count; two consecutive runs produce bit-identical x0/x1 streams.
- Assert `reset` mid-RUN: on the next cycle all outputs are at their reset values and the seeds equal the package defaults.
